// File: rtl/mips_data_mem.sv
// mips_data_mem: MEM-stage data memory for the MIPS core.
// Word RAM at 0x0xxx_xxxx plus a small I/O window at 0xF000_0000:
// LED register, free-running timer with compare interrupt, and status.
module mips_data_mem #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic [15:0] led,
    output logic        timer_irq,
    output logic        bus_err
);

    localparam logic [1:0] REG_LED    = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_CMP    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [31:0]           mem_q [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  ram_sel;
    logic                  io_sel;
    logic                  unmapped;
    logic                  ram_we;
    logic [1:0]            io_reg;
    logic [31:0]           rd_data;

    logic [15:0] led_q, led_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;
    logic        berr_q, berr_d;

    logic wr_led, wr_count, wr_cmp, wr_status;
    logic irq_set, berr_set;

    // Alias bits of the RAM region and the byte offset never affect decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[27:ADDR_WIDTH+2], mem_addr[1:0]};

    // Address decode and write strobes.
    always_comb begin
        ram_sel   = (mem_addr[31:28] == 4'h0);
        io_sel    = (mem_addr[31:4] == 28'hF00_0000);
        unmapped  = !ram_sel && !io_sel;
        io_reg    = mem_addr[3:2];
        ram_idx   = mem_addr[ADDR_WIDTH+1:2];
        // rst gating keeps a write that coincides with reset from landing in RAM.
        ram_we    = mem_wen && ram_sel && rst;
        wr_led    = mem_wen && io_sel && (io_reg == REG_LED);
        wr_count  = mem_wen && io_sel && (io_reg == REG_COUNT);
        wr_cmp    = mem_wen && io_sel && (io_reg == REG_CMP);
        wr_status = mem_wen && io_sel && (io_reg == REG_STATUS);
    end

    // Combinational read path; zero when not reading or while in reset.
    always_comb begin
        rd_data = 32'h0;
        if (ram_sel) begin
            rd_data = mem_q[ram_idx];
        end else if (io_sel) begin
            case (io_reg)
                REG_LED:    rd_data = {16'h0, led_q};
                REG_COUNT:  rd_data = count_q;
                REG_CMP:    rd_data = cmp_q;
                REG_STATUS: rd_data = {30'h0, berr_q, irq_q};
                default:    rd_data = 32'h0;
            endcase
        end
        mem_din = (mem_ren && rst) ? rd_data : 32'h0;
    end

    // Next-state for I/O registers; sticky-flag sets win over W1C clears.
    always_comb begin
        led_d    = led_q;
        count_d  = count_q + 32'd1;
        cmp_d    = cmp_q;
        irq_d    = irq_q;
        berr_d   = berr_q;
        irq_set  = (count_q == cmp_q) && (cmp_q != 32'h0);
        berr_set = (mem_ren || mem_wen) && unmapped;
        if (wr_led)   led_d   = mem_dout[15:0];
        if (wr_count) count_d = mem_dout;
        if (wr_cmp)   cmp_d   = mem_dout;
        if (wr_status && mem_dout[0]) irq_d  = 1'b0;
        if (wr_status && mem_dout[1]) berr_d = 1'b0;
        if (irq_set)  irq_d  = 1'b1;
        if (berr_set) berr_d = 1'b1;
    end

    // I/O register state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q   <= 16'h0;
            count_q <= 32'h0;
            cmp_q   <= 32'h0;
            irq_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            led_q   <= led_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            irq_q   <= irq_d;
            berr_q  <= berr_d;
        end
    end

    // RAM array: not reset, contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= mem_dout;
        end
    end

    assign led       = led_q;
    assign timer_irq = irq_q;
    assign bus_err   = berr_q;

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed bench for mips_data_mem: RAM/LED vector table plus hand-written
// timer, wrap, bus-error and reset-during-write sequences.
module tb_mips_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_dout;
    logic [31:0] mem_din;
    logic [15:0] led;
    logic        timer_irq, bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] A_LED    = 32'hF000_0000;
    localparam logic [31:0] A_COUNT  = 32'hF000_0004;
    localparam logic [31:0] A_CMP    = 32'hF000_0008;
    localparam logic [31:0] A_STATUS = 32'hF000_000C;

    mips_data_mem #(.ADDR_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .led       (led),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] dout;
        logic [31:0] exp_din;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive just after the rising edge, settle to the falling edge.
    task automatic apply(input logic wen, input logic ren, input logic [31:0] addr,
                         input logic [31:0] dout);
        @(posedge clk);
        #1;
        mem_wen  = wen;
        mem_ren  = ren;
        mem_addr = addr;
        mem_dout = dout;
        @(negedge clk);
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b0; mem_ren = 1'b1; mem_wen = 1'b0;
        mem_addr = A_LED; mem_dout = 32'h0;

        // Reset state
        #12;
        chk("reset_din", mem_din, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);
        chk("reset_irq", {31'h0, timer_irq}, 32'h0);
        chk("reset_berr", {31'h0, bus_err}, 32'h0);

        // Counter right after release: 0, then 1
        @(posedge clk);
        #1;
        rst = 1'b1; mem_ren = 1'b1; mem_addr = A_COUNT;
        @(negedge clk);
        chk("count_after_rel0", mem_din, 32'h0);
        apply(1'b0, 1'b1, A_COUNT, 32'h0);
        chk("count_after_rel1", mem_din, 32'h1);

        // RAM / LED vector table
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          16'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 16'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         32'h0,          16'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h0,         32'h0,          16'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h1111_1111, 32'h0,          16'h0};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h2222_2222, 32'h1111_1111, 16'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         32'h2222_2222, 16'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0410, 32'h0,         32'hDEAD_BEEF, 16'h0};
        vecs[8]  = '{1'b1, 1'b0, A_LED,         32'h1234_ABCD, 32'h0,          16'h0};
        vecs[9]  = '{1'b0, 1'b1, A_LED,         32'h0,         32'h0000_ABCD, 16'hABCD};
        vecs[10] = '{1'b1, 1'b0, A_CMP,         32'h0000_0055, 32'h0,          16'hABCD};
        vecs[11] = '{1'b0, 1'b1, A_CMP,         32'h0,         32'h0000_0055, 16'hABCD};
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].dout);
            chk($sformatf("vec%0d_din", i), mem_din, vecs[i].exp_din);
            chk($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
        end

        // Timer compare interrupt and W1C clear
        apply(1'b1, 1'b0, A_COUNT, 32'h0);
        apply(1'b1, 1'b0, A_CMP, 32'h5);
        idle();
        chk("irq_before_match", {31'h0, timer_irq}, 32'h0);
        for (int i = 0; i < 6; i++) idle();
        chk("irq_after_match", {31'h0, timer_irq}, 32'h1);
        apply(1'b0, 1'b1, A_STATUS, 32'h0);
        chk("status_irq", mem_din, 32'h1);
        apply(1'b1, 1'b0, A_STATUS, 32'h1);
        idle();
        chk("irq_cleared", {31'h0, timer_irq}, 32'h0);

        // Set beats clear in the same cycle
        apply(1'b1, 1'b0, A_COUNT, 32'h200);
        apply(1'b1, 1'b0, A_CMP, 32'h203);
        idle();
        apply(1'b0, 1'b1, A_COUNT, 32'h0);
        chk("count_202", mem_din, 32'h202);
        apply(1'b1, 1'b0, A_STATUS, 32'h1);
        idle();
        chk("irq_set_wins", {31'h0, timer_irq}, 32'h1);
        apply(1'b1, 1'b0, A_CMP, 32'h0);
        apply(1'b1, 1'b0, A_STATUS, 32'h1);
        idle();
        chk("irq_cleared2", {31'h0, timer_irq}, 32'h0);

        // Counter wrap
        apply(1'b1, 1'b0, A_COUNT, 32'hFFFF_FFFE);
        apply(1'b0, 1'b1, A_COUNT, 32'h0);
        chk("wrap_fffe", mem_din, 32'hFFFF_FFFE);
        apply(1'b0, 1'b1, A_COUNT, 32'h0);
        chk("wrap_ffff", mem_din, 32'hFFFF_FFFF);
        apply(1'b0, 1'b1, A_COUNT, 32'h0);
        chk("wrap_0", mem_din, 32'h0);

        // Bus error: unmapped read, W1C clear, unmapped write
        apply(1'b0, 1'b1, 32'h8000_0000, 32'h0);
        chk("unmapped_din", mem_din, 32'h0);
        chk("berr_not_yet", {31'h0, bus_err}, 32'h0);
        idle();
        chk("berr_set", {31'h0, bus_err}, 32'h1);
        apply(1'b0, 1'b1, A_STATUS, 32'h0);
        chk("status_berr", mem_din, 32'h2);
        apply(1'b1, 1'b0, A_STATUS, 32'h2);
        idle();
        chk("berr_cleared", {31'h0, bus_err}, 32'h0);
        apply(1'b1, 1'b0, 32'hF000_0010, 32'h0000_5555);
        idle();
        chk("berr_wr_set", {31'h0, bus_err}, 32'h1);
        chk("led_unmapped_wr", {16'h0, led}, 32'h0000_ABCD);
        apply(1'b1, 1'b0, A_STATUS, 32'h2);

        // Reset asserted in the middle of a RAM write
        apply(1'b1, 1'b0, A_LED, 32'h0000_FFFF);
        apply(1'b1, 1'b0, 32'h0000_0030, 32'hAAAA_5555);
        idle();
        chk("led_ffff", {16'h0, led}, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        mem_wen = 1'b1; mem_ren = 1'b1; mem_addr = 32'h0000_0030; mem_dout = 32'hBAD0_BAD0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_led", {16'h0, led}, 32'h0);
        chk("midrst_din", mem_din, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1; mem_wen = 1'b0; mem_ren = 1'b0;
        apply(1'b0, 1'b1, 32'h0000_0030, 32'h0);
        chk("midrst_ram_kept", mem_din, 32'hAAAA_5555);
        chk("midrst_led_after", {16'h0, led}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, n_fail=%0d", n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_data_mem.md
# mips_data_mem

Data-memory responder for the MIPS 5-stage core's MEM-stage port: accepts the core's read/write requests and returns read data in the same cycle. Decodes the address into a word RAM and a small memory-mapped I/O window: LED register, free-running timer with compare interrupt, and status register. Sits between the core's memory interface and board-level I/O.

## Interface
- ADDR_WIDTH, default 8: RAM word-address width; RAM holds 2^ADDR_WIDTH 32-bit words.
- clk  input  1  main clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- mem_ren  input  1  read enable from the core.
- mem_wen  input  1  write enable from the core.
- mem_addr  input  32  byte address from the core; bits [1:0] ignored (word access only).
- mem_dout  input  32  write data from the core.
- mem_din  output  32  read data to the core.
- led  output  16  LED register contents.
- timer_irq  output  1  timer interrupt pending flag.
- bus_err  output  1  sticky flag: access to an unmapped address.

## Operation
- Address decode:
  - RAM region: mem_addr[31:28] == 4'h0, word index mem_addr[ADDR_WIDTH+1:2]. Address bits above that index and below bit 28 alias.
  - 0xF000_0000 LED: write loads led <= mem_dout[15:0]; read returns {16'b0, led}.
  - 0xF000_0004 COUNT: read returns the counter; write loads it.
  - 0xF000_0008 CMP: read/write compare value.
  - 0xF000_000C STATUS: read {30'b0, bus_err, timer_irq}. Write-1-to-clear: bit0 clears timer_irq, bit1 clears bus_err.
  - Any other address is unmapped. Read returns 0. A read or write sets bus_err. A write has no other effect.
- Reads are combinational:
  - mem_din = decoded data when mem_ren = 1 and rst is deasserted.
  - Otherwise mem_din = 32'h0.
- Writes: performed on the rising edge when mem_wen = 1.
- mem_ren and mem_wen both 1 at the same address: the write commits at the edge; mem_din shows the pre-write value during that cycle.
- Timer:
  - COUNT increments by 1 every cycle, 32-bit, wraps 0xFFFF_FFFF -> 0x0000_0000.
  - A COUNT write in the same cycle takes priority over the increment: next value = mem_dout.
  - At each edge where current COUNT == CMP and CMP != 0, timer_irq is set.
  - Set and a STATUS bit0 clear in the same cycle: set wins (timer_irq stays 1).
- bus_err: an unmapped access and a STATUS bit1 clear in the same cycle: set wins.
- Reset values: led = 0, COUNT = 0, CMP = 0, timer_irq = 0, bus_err = 0, mem_din = 0. RAM contents are not cleared; they are undefined after power-up and retained across reset.
- Reset mid-operation: rst asserting asynchronously aborts any write in that cycle; no RAM or register update occurs while rst is low.

## Timing
- Read latency: 0 cycles. mem_din settles combinationally from mem_addr/mem_ren within the same cycle.
- Write latency: 1 edge. Data written at edge N is returned by a read in cycle N+1.
- COUNT read in the cycle after reset release returns 0; the following cycle returns 1.
- timer_irq and bus_err are registered. They assert in the cycle after the triggering edge condition and hold until cleared or reset.
- led is registered and changes in the cycle after the write edge.
- No backpressure: every request completes in one cycle; there is no stall output.

## Test plan
- Write 0xDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 the next cycle -> mem_din = 0xDEAD_BEEF. Read 0x0000_0014 (never written, after a prior write of 0) -> 0.
- Same-cycle ren+wen at 0x0000_0020 (old 0x1111_1111, new 0x2222_2222) -> mem_din = 0x1111_1111 that cycle, 0x2222_2222 the next.
- Write CMP = 5 after reset -> timer_irq = 1 once COUNT passes 5. STATUS read = 0x1. Write STATUS = 0x1 -> timer_irq = 0 the next cycle.
- Write COUNT = 0xFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, then 0x0000_0000 on consecutive cycles.
- Read 0x8000_0000 -> mem_din = 0, bus_err = 1 the next cycle. Write STATUS = 0x2 -> bus_err = 0. LED write 0x1234_ABCD -> led = 0xABCD.
- Assert rst low mid-write to 0x0000_0030 with LED = 0xFFFF -> led = 0, mem_din = 0 immediately, and the RAM word is unchanged after release.
